// File: rtl/request_encoder_16x4.sv
// Stores a request vector and streams out the index of each set bit, one per handshake; 1-cycle load latency.
// Define ENCODER_MSB_FIRST_EN for highest-bit-first priority (default: lowest bit first).
module request_encoder_16x4 #(
  parameter int WIDTH = 16,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] encoder_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic [IDX_W-1:0] encoder_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic [IDX_W-1:0] pick_idx;
  logic [WIDTH-1:0] pick_mask;
  logic             single;

  // The last matching iteration wins, so scan order sets the priority.
  always_comb begin
    pick_idx  = '0;
    pick_mask = '0;
`ifdef ENCODER_MSB_FIRST_EN
    for (int i = 0; i < WIDTH; i++) begin
      if (pending_q[i]) begin
        pick_idx     = IDX_W'(i);
        pick_mask    = '0;
        pick_mask[i] = 1'b1;
      end
    end
`else
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        pick_idx     = IDX_W'(i);
        pick_mask    = '0;
        pick_mask[i] = 1'b1;
      end
    end
`endif
  end

  assign single = (pending_q != '0) && ((pending_q & (pending_q - WIDTH'(1))) == '0);

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    case (state_q)
      IDLE: begin
        if (load_valid) begin
          pending_d = encoder_in;
          state_d   = (encoder_in != '0) ? SCAN : IDLE;
        end
      end
      SCAN: begin
        if (out_ready) begin
          pending_d = pending_q & ~pick_mask;
          if (single) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

  // Outputs decode registered state only; nothing combinational from the inputs.
  assign load_ready  = (state_q == IDLE);
  assign out_valid   = (state_q == SCAN);
  assign busy        = (state_q == SCAN);
  assign encoder_out = out_valid ? pick_idx : '0;
  assign out_last    = out_valid & single;

endmodule
